// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int N_ITER = 32;
  localparam int CNT_W  = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: shift-add multiply (LSB first) or
// restoring divide (MSB first) on the {acc_hi, acc_lo} pair.
module mdu_step
  import mdu_pkg::*;
(
  input  logic        is_div,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  input  logic [31:0] operand,
  output logic [31:0] nxt_hi,
  output logic [31:0] nxt_lo
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
    shifted = {acc_hi, acc_lo[31]};
    diff    = shifted - {1'b0, operand};
    if (is_div) begin
      // diff[32] set means the trial subtraction borrowed: restore
      if (!diff[32]) begin
        nxt_hi = diff[31:0];
        nxt_lo = {acc_lo[30:0], 1'b1};
      end else begin
        nxt_hi = shifted[31:0];
        nxt_lo = {acc_lo[30:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[32:1];
      nxt_lo = {sum[0], acc_lo[31:1]};
    end
  end

endmodule

// File: rtl/mdu_sched.sv
// Iterative multiply/divide scheduler owning HI/LO, the FSM and the
// pipeline stall request toward the hazard logic.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepts start (priority) or mthi/mtlo writes
// RUN     | one datapath iteration per cycle, 32 iterations
// DONE    | done pulse, sign fix-up, HI/LO written at closing edge
module mdu_sched
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        hilo_rd,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] hilo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc_hi;
  logic [31:0]      acc_lo;
  logic [31:0]      operand_b;
  logic [1:0]       op_q;
  logic             sign_a;
  logic             sign_b;

  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic        is_signed;
  logic        start_signed;
  logic        neg_res;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  mdu_step u_step (
    .is_div  (op_q[1]),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand_b),
    .nxt_hi  (step_hi),
    .nxt_lo  (step_lo)
  );

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);
  assign stall = busy & (start | hilo_rd | hilo_we);

  assign start_signed = ~op[0];

  always_comb begin
    is_signed = ~op_q[0];
    neg_res   = is_signed & (sign_a ^ sign_b);
    prod_fix  = neg_res ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
    // a zero divisor leaves the all-ones quotient untouched by sign fix-up
    quo_fix   = (neg_res && (operand_b != 32'd0)) ? (~acc_lo + 32'd1) : acc_lo;
    rem_fix   = (is_signed && sign_a) ? (~acc_hi + 32'd1) : acc_hi;
    if (op_q[1]) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[63:32];
      res_lo = prod_fix[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      op_q      <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= op;
            sign_a    <= start_signed & opa[31];
            sign_b    <= start_signed & opb[31];
            acc_hi    <= '0;
            acc_lo    <= start_signed ? abs32(opa) : opa;
            operand_b <= start_signed ? abs32(opb) : opb;
            cnt       <= '0;
            state     <= ST_RUN;
          end else if (hilo_we) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
          end
        end
        ST_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: a reference model pushes expected {HI,LO}
// into a queue at issue time; results are popped when the unit completes.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        hilo_rd;
  logic        hilo_we;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] arch;

  always #5 clk = ~clk;

  mdu_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .hilo_rd    (hilo_rd),
    .hilo_we    (hilo_we),
    .hilo_sel   (hilo_sel),
    .hilo_wdata (hilo_wdata),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .stall      (stall)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb_v;
    longint      q;
    longint      r;
    logic [63:0] pu;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    case (o)
      2'b00: begin
        q = sa * sb_v;
        return q;
      end
      2'b01: begin
        pu = {32'd0, a} * {32'd0, b};
        return pu;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb_v;
        r = sa % sb_v;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
  endtask

  task automatic accept(input string tag);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic finish_op(input string tag, output int cyc);
    logic [63:0] exp;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hold"}, {hi, lo}, arch);
    @(negedge clk);
    chk({tag, "_done_width"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    exp  = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    arch = exp;
    chk({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    issue(o, a, b);
    accept(tag);
    finish_op(tag, cyc);
    chk({tag, "_latency"}, 64'(cyc), 64'd32);
  endtask

  initial begin
    int cyc;
    int bad;
    int n_done;
    reset = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    hilo_rd = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    arch = 64'd0;

    // mthi then mtlo
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("mthi", {hi, lo}, {32'hCAFE_0001, 32'd0});
    hilo_sel = 1'b0; hilo_wdata = 32'h5A5A_0002;
    @(negedge clk);
    hilo_we = 1'b0;
    chk("mtlo", {hi, lo}, {32'hCAFE_0001, 32'h5A5A_0002});
    arch = {32'hCAFE_0001, 32'h5A5A_0002};

    run_op("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_dz", 2'b11, 32'd10, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_neg_dz", 2'b10, 32'hFFFF_FFF9, 32'd0);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7);
    run_op("div_p9dm4", 2'b10, 32'd9, 32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) run_op("rnd", 2'(i), $urandom, $urandom);

    // start and mt together in IDLE: start wins, mt dropped
    issue(2'b01, 32'd6, 32'd7);
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
    accept("start_vs_mt");
    chk("mt_dropped", {hi, lo}, arch);
    chk("mt_busy_stall", 64'(stall), 64'd1);
    hilo_we = 1'b0;
    finish_op("start_vs_mt", cyc);

    // hilo_rd held from E5 through completion
    issue(2'b10, 32'd1000, 32'hFFFF_FFF7);
    accept("rd_hold");
    repeat (4) @(negedge clk);
    hilo_rd = 1'b1;
    bad = 0; cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (stall !== 1'b1) bad++;
    end
    chk("rd_stall_run", 64'(bad), 64'd0);
    chk("rd_stall_done", 64'(stall), 64'd1);
    finish_op("rd_hold", cyc);
    chk("rd_stall_idle", 64'(stall), 64'd0);
    hilo_rd = 1'b0;

    // second start arrives during RUN and is held until IDLE
    issue(2'b11, 32'd1000, 32'd3);
    accept("first");
    repeat (3) @(negedge clk);
    sb.push_back(model(2'b00, 32'hFFFF_FFFC, 32'd9));
    start = 1'b1; op = 2'b00; opa = 32'hFFFF_FFFC; opb = 32'd9;
    @(negedge clk);
    chk("second_stall", 64'(stall), 64'd1);
    finish_op("first", cyc);
    chk("second_idle_stall", 64'(stall), 64'd0);
    accept("second");
    finish_op("second", cyc);

    // reset while counter = 10 aborts with no done pulse
    @(negedge clk);
    start = 1'b1; op = 2'b01; opa = 32'd123; opb = 32'd456;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    arch = 64'd0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);

    // reset outranks start and mt in the same cycle
    hilo_wdata = 32'h1111_2222; hilo_we = 1'b1; hilo_sel = 1'b0;
    start = 1'b1; op = 2'b00; opa = 32'd5; opb = 32'd5;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; hilo_we = 1'b0;
    chk("rst_prio_busy", 64'(busy), 64'd0);
    chk("rst_prio_hilo", {hi, lo}, 64'd0);

    run_op("post_rst", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
